player_health_ctrl: RTL and testbench

Parametrised successor to the player-location/collision logic in the shooter game. It owns the player position, applies clamped D-pad movement, and box-tests the player against N enemy/projectile slots. It adds a lives counter, a post-hit invulnerability window and a game-over state. It sits between the input debouncers, the enemy/pattern generator and the VGA renderer/HUD, all clocked by GameClock.

---
 rtl/player_health_ctrl_if.sv | 31 +++
 rtl/player_health_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_player_health_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_health_ctrl_if.sv
// Bundle between the player controller and its input, enemy and display neighbours.
interface player_health_ctrl_if #(
    parameter int unsigned W       = 8,
    parameter int unsigned N_ENEMY = 10
);
    logic                   start;
    logic                   left;
    logic                   right;
    logic                   up;
    logic                   down;
    logic [N_ENEMY*W-1:0]   ex;
    logic [N_ENEMY*W-1:0]   ey;
    logic [N_ENEMY-1:0]     e_valid;
    logic [W-1:0]           xin;
    logic [W-1:0]           yin;
    logic                   hurt;
    logic [3:0]             lives;
    logic                   invuln;
    logic                   game_over;
    logic [1:0]             state;

    modport master (
        output start, left, right, up, down, ex, ey, e_valid,
        input  xin, yin, hurt, lives, invuln, game_over, state
    );

    modport slave (
        input  start, left, right, up, down, ex, ey, e_valid,
        output xin, yin, hurt, lives, invuln, game_over, state
    );
endinterface

// File: rtl/player_health_ctrl.sv
// Player position, clamped D-pad movement, box collision against N slots,
// lives counter, post-hit invulnerability window and game-over handling.
// W and N_ENEMY must match the parameters of the connected interface.
module player_health_ctrl #(
    parameter int unsigned W       = 8,
    parameter int unsigned N_ENEMY = 10,
    parameter int unsigned X_MIN   = 10,
    parameter int unsigned X_MAX   = 190,
    parameter int unsigned Y_MIN   = 40,
    parameter int unsigned Y_MAX   = 230,
    parameter int unsigned X_SPAWN = 100,
    parameter int unsigned Y_SPAWN = 190,
    parameter int unsigned STEP    = 2,
    parameter int unsigned HIT_R   = 5,
    parameter int unsigned LIVES   = 3,
    parameter int unsigned INVULN  = 120
) (
    input  logic                 GameClock,
    input  logic                 reset,
    player_health_ctrl_if.slave  bus
);

    localparam int unsigned TW = (INVULN > 1) ? $clog2(INVULN) : 1;

    localparam logic [W:0]    XLowLimit  = (W+1)'(X_MIN + STEP);
    localparam logic [W:0]    YLowLimit  = (W+1)'(Y_MIN + STEP);
    localparam logic [W:0]    XMaxExt    = (W+1)'(X_MAX);
    localparam logic [W:0]    YMaxExt    = (W+1)'(Y_MAX);
    localparam logic [W:0]    StepExt    = (W+1)'(STEP);
    localparam logic [W:0]    HitRExt    = (W+1)'(HIT_R);
    localparam logic [W-1:0]  XSpawn     = W'(X_SPAWN);
    localparam logic [W-1:0]  YSpawn     = W'(Y_SPAWN);
    localparam logic [W-1:0]  XMin       = W'(X_MIN);
    localparam logic [W-1:0]  YMin       = W'(Y_MIN);
    localparam logic [3:0]    LivesInit  = 4'(LIVES);
    localparam logic [TW-1:0] TimerLoad  = TW'(INVULN - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StInv  = 2'd2,
        StOver = 2'd3
    } state_e;

    state_e        r_state, w_state_next;
    logic [W-1:0]  r_x, r_y, w_x_next, w_y_next, w_x_move, w_y_move;
    logic [3:0]    r_lives, w_lives_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic          r_hurt, w_hurt_next;
    logic          r_invuln, r_game_over;
    logic          w_hit_any;

    logic [W:0]    w_x_ext, w_y_ext, w_x_inc, w_y_inc;
    logic [W:0]    w_adx [N_ENEMY];
    logic [W:0]    w_ady [N_ENEMY];

    // Clamped movement; W+1-bit arithmetic so nothing wraps at the coordinate extremes.
    always_comb begin
        w_x_ext  = {1'b0, r_x};
        w_y_ext  = {1'b0, r_y};
        w_x_inc  = w_x_ext + StepExt;
        w_y_inc  = w_y_ext + StepExt;
        w_x_move = r_x;
        w_y_move = r_y;
        if (bus.left && !bus.right) begin
            w_x_move = (w_x_ext >= XLowLimit) ? r_x - W'(STEP) : XMin;
        end else if (bus.right && !bus.left) begin
            w_x_move = (w_x_inc > XMaxExt) ? XMaxExt[W-1:0] : w_x_inc[W-1:0];
        end
        if (bus.up && !bus.down) begin
            w_y_move = (w_y_ext >= YLowLimit) ? r_y - W'(STEP) : YMin;
        end else if (bus.down && !bus.up) begin
            w_y_move = (w_y_inc > YMaxExt) ? YMaxExt[W-1:0] : w_y_inc[W-1:0];
        end
    end

    // Box test of the registered position against every valid slot.
    always_comb begin
        w_hit_any = 1'b0;
        for (int i = 0; i < N_ENEMY; i++) begin
            w_adx[i] = ({1'b0, r_x} >= {1'b0, bus.ex[i*W +: W]}) ?
                       {1'b0, r_x} - {1'b0, bus.ex[i*W +: W]} :
                       {1'b0, bus.ex[i*W +: W]} - {1'b0, r_x};
            w_ady[i] = ({1'b0, r_y} >= {1'b0, bus.ey[i*W +: W]}) ?
                       {1'b0, r_y} - {1'b0, bus.ey[i*W +: W]} :
                       {1'b0, bus.ey[i*W +: W]} - {1'b0, r_y};
            if (bus.e_valid[i] && (w_adx[i] < HitRExt) && (w_ady[i] < HitRExt)) begin
                w_hit_any = 1'b1;
            end
        end
    end

    // Next-state, position, lives and timer; start=0 beats a simultaneous hit.
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_lives_next = r_lives;
        w_timer_next = r_timer;
        w_hurt_next  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_x_next     = XSpawn;
                w_y_next     = YSpawn;
                w_lives_next = LivesInit;
                w_timer_next = '0;
                if (bus.start) w_state_next = StPlay;
            end
            StPlay, StInv: begin
                if (!bus.start) begin
                    w_state_next = StIdle;
                    w_x_next     = XSpawn;
                    w_y_next     = YSpawn;
                    w_lives_next = LivesInit;
                    w_timer_next = '0;
                end else begin
                    w_x_next = w_x_move;
                    w_y_next = w_y_move;
                    if (r_state == StPlay) begin
                        if (w_hit_any) begin
                            w_hurt_next  = 1'b1;
                            w_lives_next = r_lives - 4'd1;
                            if (r_lives == 4'd1) begin
                                w_state_next = StOver;
                            end else begin
                                w_state_next = StInv;
                                w_timer_next = TimerLoad;
                            end
                        end
                    end else if (r_timer == '0) begin
                        w_state_next = StPlay;
                    end else begin
                        w_timer_next = r_timer - TW'(1);
                    end
                end
            end
            StOver: begin
                if (!bus.start) begin
                    w_state_next = StIdle;
                    w_x_next     = XSpawn;
                    w_y_next     = YSpawn;
                    w_lives_next = LivesInit;
                    w_timer_next = '0;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State and registered outputs; flags are derived from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge GameClock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_x         <= XSpawn;
            r_y         <= YSpawn;
            r_lives     <= LivesInit;
            r_timer     <= '0;
            r_hurt      <= 1'b0;
            r_invuln    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_lives     <= w_lives_next;
            r_timer     <= w_timer_next;
            r_hurt      <= w_hurt_next;
            r_invuln    <= (w_state_next == StInv);
            r_game_over <= (w_state_next == StOver);
        end
    end

    assign bus.xin       = r_x;
    assign bus.yin       = r_y;
    assign bus.hurt      = r_hurt;
    assign bus.lives     = r_lives;
    assign bus.invuln    = r_invuln;
    assign bus.game_over = r_game_over;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_player_health_ctrl.sv
// Scoreboard bench: a behavioural model predicts every output per cycle, the
// prediction is queued when inputs are driven and compared after the edge.
module tb_player_health_ctrl;

    localparam int NE = 10;
    localparam int INV_LEN = 120;

    logic GameClock = 1'b0;
    logic reset = 1'b1;

    always #5 GameClock = ~GameClock;

    player_health_ctrl_if #(.W(8), .N_ENEMY(NE)) bus ();
    player_health_ctrl_if #(.W(8), .N_ENEMY(NE)) bus2 ();

    player_health_ctrl dut (
        .GameClock (GameClock),
        .reset     (reset),
        .bus       (bus.slave)
    );

    // Edge-of-screen variant: x starts odd next to 0 so an unclamped step would wrap.
    player_health_ctrl #(.X_MIN(0), .X_SPAWN(1)) dut_edge (
        .GameClock (GameClock),
        .reset     (reset),
        .bus       (bus2.slave)
    );

    typedef struct {
        int x;
        int y;
        int lives;
        int state;
        int hurt;
        int inv;
        int go;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    int slot_x [NE];
    int slot_y [NE];
    bit slot_v [NE];

    int m_x, m_y, m_lives, m_state, m_timer, m_hurt;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic apply_slots();
        for (int i = 0; i < NE; i++) begin
            bus.ex[i*8 +: 8]  = 8'(slot_x[i]);
            bus.ey[i*8 +: 8]  = 8'(slot_y[i]);
            bus.e_valid[i]    = slot_v[i];
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y, input bit v);
        slot_x[i] = x;
        slot_y[i] = y;
        slot_v[i] = v;
        apply_slots();
    endtask

    task automatic clear_slots();
        for (int i = 0; i < NE; i++) begin
            slot_x[i] = 255;
            slot_y[i] = 255;
            slot_v[i] = 1'b0;
        end
        apply_slots();
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit model_hit();
        bit h = 1'b0;
        for (int i = 0; i < NE; i++) begin
            if (slot_v[i] && iabs(m_x - slot_x[i]) < 5 && iabs(m_y - slot_y[i]) < 5) h = 1'b1;
        end
        return h;
    endfunction

    task automatic model_spawn();
        m_x = 100;
        m_y = 190;
        m_lives = 3;
        m_timer = 0;
    endtask

    // Advances the model by one GameClock using the inputs currently driven.
    task automatic model_update();
        bit h;
        int nx, ny;
        h = model_hit();
        m_hurt = 0;
        if (reset) begin
            model_spawn();
            m_state = 0;
        end else begin
            case (m_state)
                0: begin
                    model_spawn();
                    if (bus.start) m_state = 1;
                end
                1, 2: begin
                    if (!bus.start) begin
                        model_spawn();
                        m_state = 0;
                    end else begin
                        nx = m_x;
                        ny = m_y;
                        if (bus.left && !bus.right) nx = (m_x - 2 < 10) ? 10 : m_x - 2;
                        else if (bus.right && !bus.left) nx = (m_x + 2 > 190) ? 190 : m_x + 2;
                        if (bus.up && !bus.down) ny = (m_y - 2 < 40) ? 40 : m_y - 2;
                        else if (bus.down && !bus.up) ny = (m_y + 2 > 230) ? 230 : m_y + 2;
                        if (m_state == 1) begin
                            if (h) begin
                                m_hurt = 1;
                                m_lives--;
                                if (m_lives == 0) m_state = 3;
                                else begin
                                    m_state = 2;
                                    m_timer = INV_LEN - 1;
                                end
                            end
                        end else if (m_timer == 0) begin
                            m_state = 1;
                        end else begin
                            m_timer--;
                        end
                        m_x = nx;
                        m_y = ny;
                    end
                end
                default: begin
                    if (!bus.start) begin
                        model_spawn();
                        m_state = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        exp_t e;
        model_update();
        e.x = m_x;
        e.y = m_y;
        e.lives = m_lives;
        e.state = m_state;
        e.hurt = m_hurt;
        e.inv = (m_state == 2) ? 1 : 0;
        e.go = (m_state == 3) ? 1 : 0;
        sb.push_back(e);
        @(posedge GameClock);
        #1;
        e = sb.pop_front();
        check_eq("xin", int'(bus.xin), e.x);
        check_eq("yin", int'(bus.yin), e.y);
        check_eq("lives", int'(bus.lives), e.lives);
        check_eq("state", int'(bus.state), e.state);
        check_eq("hurt", int'(bus.hurt), e.hurt);
        check_eq("invuln", int'(bus.invuln), e.inv);
        check_eq("game_over", int'(bus.game_over), e.go);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_dir(input bit l, input bit r, input bit u, input bit d);
        bus.left = l;
        bus.right = r;
        bus.up = u;
        bus.down = d;
    endtask

    initial begin
        bus.start = 1'b0;
        set_dir(0, 0, 0, 0);
        bus2.start = 1'b0;
        bus2.left = 1'b0;
        bus2.right = 1'b0;
        bus2.up = 1'b0;
        bus2.down = 1'b0;
        bus2.ex = '1;
        bus2.ey = '1;
        bus2.e_valid = '0;
        clear_slots();
        m_state = 0;
        m_hurt = 0;
        model_spawn();

        // Reset values
        reset = 1'b1;
        steps(2);
        check_eq("rst_x", int'(bus.xin), 100);
        check_eq("rst_y", int'(bus.yin), 190);
        check_eq("rst_lives", int'(bus.lives), 3);
        check_eq("rst_state", int'(bus.state), 0);
        reset = 1'b0;

        // Right saturates at X_MAX after 45 moves, then left+right holds
        bus.start = 1'b1;
        step();
        set_dir(0, 1, 0, 0);
        steps(44);
        check_eq("x_before_sat", int'(bus.xin), 188);
        step();
        check_eq("x_sat", int'(bus.xin), 190);
        steps(5);
        set_dir(1, 1, 0, 0);
        steps(3);
        check_eq("x_lr_hold", int'(bus.xin), 190);

        // Up from 190 down to Y_MIN and held there
        set_dir(0, 0, 1, 0);
        steps(80);
        check_eq("y_min", int'(bus.yin), 40);
        set_dir(0, 1, 0, 1);
        steps(3);

        // Back to spawn via start=0
        set_dir(0, 0, 0, 0);
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        step();

        // Near misses and an invalid overlapping slot
        set_slot(2, 105, 190, 1);
        steps(2);
        set_slot(2, 100, 196, 1);
        steps(2);
        set_slot(2, 100, 190, 0);
        steps(2);
        set_slot(7, 255, 255, 1);
        steps(2);
        check_eq("miss_lives", int'(bus.lives), 3);
        clear_slots();

        // First hit, held overlap through the window, re-hit, then game over
        set_slot(3, 104, 190, 1);
        step();
        check_eq("hit1_hurt", int'(bus.hurt), 1);
        check_eq("hit1_lives", int'(bus.lives), 2);
        check_eq("hit1_state", int'(bus.state), 2);
        steps(INV_LEN);
        check_eq("inv_end_state", int'(bus.state), 1);
        step();
        check_eq("hit2_hurt", int'(bus.hurt), 1);
        check_eq("hit2_lives", int'(bus.lives), 1);
        steps(INV_LEN + 1);
        check_eq("hit3_lives", int'(bus.lives), 0);
        check_eq("hit3_over", int'(bus.game_over), 1);
        set_dir(0, 1, 1, 0);
        steps(3);
        check_eq("over_frozen_x", int'(bus.xin), 100);
        set_dir(0, 0, 0, 0);
        bus.start = 1'b0;
        step();
        check_eq("over_idle_lives", int'(bus.lives), 3);
        clear_slots();

        // Several overlapping slots cost exactly one life
        bus.start = 1'b1;
        step();
        set_slot(0, 100, 190, 1);
        set_slot(1, 97, 187, 1);
        set_slot(3, 103, 193, 1);
        step();
        check_eq("multi_lives", int'(bus.lives), 2);

        // Reset mid-window (timer at 50)
        steps(69);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midinv_rst_state", int'(bus.state), 0);
        check_eq("midinv_rst_inv", int'(bus.invuln), 0);
        clear_slots();
        step();
        step();

        // Hit coinciding with start=0: the return to IDLE wins
        set_slot(5, 101, 191, 1);
        bus.start = 1'b0;
        step();
        check_eq("hit_stop_hurt", int'(bus.hurt), 0);
        check_eq("hit_stop_lives", int'(bus.lives), 3);
        clear_slots();

        // Left from x=1 with X_MIN=0 clamps to 0 instead of wrapping
        bus2.start = 1'b1;
        @(posedge GameClock);
        #1;
        check_eq("edge_spawn", int'(bus2.xin), 1);
        bus2.left = 1'b1;
        @(posedge GameClock);
        #1;
        check_eq("edge_clamp", int'(bus2.xin), 0);
        @(posedge GameClock);
        #1;
        check_eq("edge_hold", int'(bus2.xin), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
